data_memory_lsu: RTL and testbench
==================================

DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 64, data/address width
- DEPTH, 32, number of XLEN-bit words
- LATENCY, 1, accept-to-response cycles, legal 1..4
- INIT_MODE, 1, 0 = clear to zero, 1 = word i loaded with value i
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, reset, synchronous, active-high
- req_valid, in, 1, request present
- req_ready, out, 1, request accepted when high together with req_valid
- req_we, in, 1, 1 = store, 0 = load
- req_size, in, 2, 00 byte, 01 half, 10 word, 11 double
- req_unsigned, in, 1, zero-extend load result
- req_addr, in, XLEN, byte address
- req_wdata, in, XLEN, store data, low bytes used
- rsp_valid, out, 1, one-cycle response pulse
- rsp_rdata, out, XLEN, load result, 0 for stores and faults
- rsp_fault, out, 1, misaligned or out-of-range access
- busy, out, 1, high in any state except IDLE

Function
REQ-003 The FSM SHALL have states INIT, IDLE, WAIT and RESP.
REQ-004 INIT SHALL write one word per cycle (word i = 0 or i per INIT_MODE), DEPTH cycles total, then go to IDLE; req_ready SHALL be 0 during INIT.
REQ-005 req_ready SHALL be 1 only in IDLE; a handshake SHALL capture all req_* fields and leave IDLE.
REQ-006 rsp_valid SHALL be 1 exactly LATENCY cycles after the accept edge (WAIT holds LATENCY-1 cycles, then RESP lasts 1 cycle) and SHALL return to IDLE next; one request is outstanding at a time.
REQ-007 Word index SHALL be addr >> 3 (XLEN=64) and byte lane addr[2:0]; byte order is little-endian.
REQ-008 Misaligned SHALL mean addr mod 2^size != 0; out-of-range SHALL mean word index >= DEPTH; either SHALL set rsp_fault=1, rsp_rdata=0 and suppress the store.
REQ-009 A store SHALL merge only the 2^size selected bytes into the addressed word (other bytes unchanged) on the RESP-cycle edge.
REQ-010 A load SHALL extract the selected bytes, sign-extend them, or zero-extend when req_unsigned=1; the double size ignores req_unsigned.
REQ-011 A load issued after a store response SHALL return the stored data.
REQ-012 rsp_rdata and rsp_fault SHALL be held valid only while rsp_valid=1 and SHALL be 0 otherwise.
REQ-013 Memory contents SHALL persist across requests and change only by INIT or a non-faulting store.

Reset
REQ-014 reset=1 SHALL force INIT, clear the init counter, and drive rsp_valid=0, rsp_fault=0, rsp_rdata=0, req_ready=0 and busy=1 on the next edge.
REQ-015 Reset during WAIT or RESP SHALL abort the request with no response and no store commit, then re-run INIT.

Structure
REQ-016 Shared package dmem_pkg SHALL hold the size encodings, FSM state enum and INIT_MODE constants.
REQ-017 Byte-lane extract/merge and extension SHALL live in combinational sub-module dmem_lane_align; the FSM and storage SHALL live in data_memory_lsu.

Verification
REQ-018 Release reset with INIT_MODE=1: req_ready=0 for 32 cycles, then load double at addr 0x38 -> rsp_rdata=7 after LATENCY cycles.
REQ-019 Store byte 0xAB at 0x09 over word 1, then load byte signed at 0x09 -> 0xFFFF_FFFF_FFFF_FFAB; load byte unsigned -> 0xAB; load double at 0x08 -> 0x0000_0000_0000_AB01.
REQ-020 Load half at 0x03 -> rsp_fault=1, rsp_rdata=0; store double at 0x100 (index 32) -> rsp_fault=1 and memory unchanged.
REQ-021 LATENCY=3 with back-to-back req_valid -> accepts 4 cycles apart, rsp_valid pulses 3 cycles after each accept, and req_ready=0 in between.
REQ-022 Assert reset during WAIT of a store of 0x55 to 0x10 -> no rsp_valid, and after re-INIT a load double at 0x10 returns 2.

Source files
------------

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory load/store unit: access size
// encodings, controller state enum, INIT_MODE selector values and the
// alignment helper used for fault detection.
// ----------------------------------------------------------------------------
package dmem_pkg;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } size_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // INIT_MODE values: clear every word, or load word i with i.
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    // Byte-lane select width for 64-bit words.
    localparam int LANE_BITS = 3;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [LANE_BITS-1:0] align_mask(input size_e size);
        case (size)
            SIZE_BYTE: align_mask = 3'b000;
            SIZE_HALF: align_mask = 3'b001;
            SIZE_WORD: align_mask = 3'b011;
            default:   align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane logic for the load/store unit (little-endian).
// Ports:
//   word        - current contents of the addressed memory word
//   wdata       - store data; only the low 2^size bytes are used
//   lane        - byte offset of the access within the word
//   size        - access size
//   is_unsigned - zero-extend instead of sign-extend narrow loads
//   load_data   - selected bytes, extended to XLEN
//   merged      - word with the selected bytes replaced by store data
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]      word,
    input  logic [XLEN-1:0]      wdata,
    input  logic [LANE_BITS-1:0] lane,
    input  size_e                size,
    input  logic                 is_unsigned,
    output logic [XLEN-1:0]      load_data,
    output logic [XLEN-1:0]      merged
);

    logic [LANE_BITS+2:0] shamt;
    logic [XLEN-1:0]      shifted;
    logic [XLEN-1:0]      byte_mask;
    logic [XLEN-1:0]      lane_mask;

    assign shamt = {lane, 3'b000};

    // Shift the addressed lane down to bit 0 for loads, and build a mask of
    // the bytes touched so a store rewrites only those bytes of the word.
    always_comb begin
        shifted   = word >> shamt;
        load_data = shifted;
        byte_mask = '1;
        case (size)
            SIZE_BYTE: begin
                byte_mask = XLEN'(64'h0000_0000_0000_00FF);
                load_data = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_mask = XLEN'(64'h0000_0000_0000_FFFF);
                load_data = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                byte_mask = XLEN'(64'h0000_0000_FFFF_FFFF);
                load_data = {{(XLEN-32){~is_unsigned & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                byte_mask = '1;
                load_data = shifted;
            end
        endcase
        lane_mask = byte_mask << shamt;
        merged    = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/data_memory_lsu.sv
// ----------------------------------------------------------------------------
// data_memory_lsu
// Single-outstanding load/store unit in front of a DEPTH x XLEN word memory.
// After reset the memory is initialised one word per cycle, then requests are
// accepted in IDLE and answered with a one-cycle response LATENCY cycles after
// the accept edge.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_we              - 1 = store, 0 = load
//   req_size            - 00 byte, 01 half, 10 word, 11 double
//   req_unsigned        - zero-extend narrow loads
//   req_addr            - byte address
//   req_wdata           - store data, low bytes used
//   rsp_valid           - one-cycle response pulse
//   rsp_rdata           - load result (0 for stores/faults and outside rsp_valid)
//   rsp_fault           - misaligned or out-of-range access
//   busy                - high in every state except IDLE
// ----------------------------------------------------------------------------
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 32,
    parameter int LATENCY   = 1,
    parameter int INIT_MODE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic            busy
);

    localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] WAIT_LAST = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e           state;
    logic [IW-1:0]    init_cnt;
    logic [1:0]       lat_cnt;

    logic             cap_we;
    size_e            cap_size;
    logic             cap_unsigned;
    logic [XLEN-1:0]  cap_addr;
    logic [XLEN-1:0]  cap_wdata;

    logic [XLEN-1:0]  mem [DEPTH];

    logic                 use_live;
    logic                 cur_we;
    size_e                cur_size;
    logic                 cur_unsigned;
    logic [XLEN-1:0]      cur_addr;
    logic [XLEN-1:0]      cur_wdata;
    logic [XLEN-LANE_BITS-1:0] word_idx;
    logic [LANE_BITS-1:0] lane;
    logic                 out_of_range;
    logic                 misaligned;
    logic                 fault;
    logic [XLEN-1:0]      rd_word;
    logic [XLEN-1:0]      load_data;
    logic [XLEN-1:0]      merged;
    logic [XLEN-1:0]      resp_data;

    // In IDLE the live request is decoded so LATENCY=1 can answer on the
    // accept edge; afterwards the captured copy drives the same datapath.
    always_comb begin
        use_live     = (state == ST_IDLE);
        cur_we       = use_live ? req_we               : cap_we;
        cur_size     = use_live ? size_e'(req_size)    : cap_size;
        cur_unsigned = use_live ? req_unsigned         : cap_unsigned;
        cur_addr     = use_live ? req_addr             : cap_addr;
        cur_wdata    = use_live ? req_wdata            : cap_wdata;
        word_idx     = cur_addr[XLEN-1:LANE_BITS];
        lane         = cur_addr[LANE_BITS-1:0];
        out_of_range = (word_idx >= (XLEN-LANE_BITS)'(DEPTH));
        misaligned   = ((lane & align_mask(cur_size)) != '0);
        fault        = out_of_range | misaligned;
        rd_word      = out_of_range ? '0 : mem[word_idx[IW-1:0]];
        resp_data    = (fault | cur_we) ? '0 : load_data;
    end

    dmem_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .word        (rd_word),
        .wdata       (cur_wdata),
        .lane        (lane),
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Controller and storage. Outputs are registered so rsp_* are already
    // valid in the RESP cycle and zero elsewhere; a store commits on the edge
    // that ends RESP, so a reset arriving before then discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    mem[init_cnt] <= (INIT_MODE == INIT_INDEX) ? XLEN'(init_cnt)
                                                               : {XLEN{1'b0}};
                    if (init_cnt == IW'(DEPTH - 1)) begin
                        init_cnt  <= '0;
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we       <= req_we;
                        cap_size     <= size_e'(req_size);
                        cap_unsigned <= req_unsigned;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        lat_cnt      <= '0;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= resp_data;
                            rsp_fault <= fault;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == WAIT_LAST) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= resp_data;
                        rsp_fault <= fault;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (cap_we && !fault) begin
                        mem[word_idx[IW-1:0]] <= merged;
                    end
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_fault <= 1'b0;
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// ----------------------------------------------------------------------------
// tb_data_memory_lsu
// Self-checking bench for data_memory_lsu (LATENCY=3, INIT_MODE=1).
// A byte-array reference model mirrors memory contents; directed vectors,
// random requests, back-to-back spacing and reset-abort sequences are checked.
// ----------------------------------------------------------------------------
module tb_data_memory_lsu;

    localparam int XLEN  = 64;
    localparam int DEPTH = 32;
    localparam int LAT   = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_fault;
    logic            busy;

    int  n_checks = 0;
    int  n_fail   = 0;
    time t_accept;

    byte unsigned model_mem [DEPTH*8];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [20];

    data_memory_lsu #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .INIT_MODE (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .busy         (busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something deadlocks beyond the per-wait bounds.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference memory after INIT: word w holds the value w.
    task automatic model_init();
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < 8; b++) begin
                model_mem[w*8+b] = (b == 0) ? 8'(w) : 8'h00;
            end
        end
    endtask

    // Behavioural access: byte-addressed array, little-endian assembly.
    task automatic model_access(input logic we, input logic [1:0] size,
                                input logic uns, input logic [63:0] addr,
                                input logic [63:0] wdata,
                                output logic [63:0] r, output logic f);
        int          n;
        int          base;
        logic [63:0] v;
        n = 1 << size;
        f = ((addr % n) != 0) || ((addr / 8) >= DEPTH);
        r = '0;
        if (!f) begin
            base = int'(addr);
            if (we) begin
                for (int k = 0; k < n; k++) model_mem[base+k] = wdata[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v |= 64'(model_mem[base+k]) << (8*k);
                if (!uns && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 64'd1);
                r = v;
            end
        end
    endtask

    // Issue one request from a negedge and follow it cycle by cycle to the
    // IDLE cycle after its response. Returns at that negedge.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic uns, input logic [63:0] addr,
                                 input logic [63:0] wdata, input string tag,
                                 output logic [63:0] rdata, output logic flt);
        int waitc;
        rdata        = '0;
        flt          = 1'b0;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        waitc        = 0;
        while (!req_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            checkOutput({tag, "_accept_timeout"}, 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_accept = $time;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = {$urandom, $urandom};
                checkOutput({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
            end
            checkOutput($sformatf("%s_ready_c%0d", tag, c), 64'(req_ready), 64'd0);
            checkOutput($sformatf("%s_rsp_valid_c%0d", tag, c), 64'(rsp_valid),
                        (c == LAT) ? 64'd1 : 64'd0);
            if (c == LAT) begin
                rdata = rsp_rdata;
                flt   = rsp_fault;
            end
        end
        @(negedge clk);
        checkOutput({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_rdata_idle_zero"}, rsp_rdata, 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    // Wait for INIT to complete after reset release; returns cycle count.
    task automatic waitInit(output int cnt);
        cnt = 0;
        while (!req_ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 16) checkOutput("busy_during_init", 64'(busy), 64'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] r, exp_r;
        logic        f, exp_f;
        int          cnt;
        time         t0, t1, t2;
        int          n;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        model_init();

        // Directed vectors, applied in order against the initial memory image.
        vecs[0]  = '{1'b0, 2'd3, 1'b0, 64'h38,  64'h0,          64'h7,                  1'b0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 64'h09,  64'hAB,         64'h0,                  1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 64'h09,  64'h0,          64'hFFFF_FFFF_FFFF_FFAB, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 64'h09,  64'h0,          64'hAB,                 1'b0};
        vecs[4]  = '{1'b0, 2'd3, 1'b0, 64'h08,  64'h0,          64'hAB01,               1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 64'h03,  64'h0,          64'h0,                  1'b1};
        vecs[6]  = '{1'b1, 2'd3, 1'b0, 64'h100, 64'hDEADBEEF,   64'h0,                  1'b1};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'hF8,  64'h0,          64'd31,                 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 64'h12,  64'hFFFF_1234,  64'h0,                  1'b0};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 64'h10,  64'h0,          64'h1234_0002,          1'b0};
        vecs[10] = '{1'b1, 2'd2, 1'b0, 64'h1C,  64'h8000_0001,  64'h0,                  1'b0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 64'h1C,  64'h0,          64'hFFFF_FFFF_8000_0001, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 1'b1, 64'h1C,  64'h0,          64'h8000_0001,          1'b0};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 64'h18,  64'h0,          64'h8000_0001_0000_0003, 1'b0};
        vecs[14] = '{1'b1, 2'd2, 1'b0, 64'h22,  64'h1111_1111,  64'h0,                  1'b1};
        vecs[15] = '{1'b0, 2'd3, 1'b0, 64'h20,  64'h0,          64'h4,                  1'b0};
        vecs[16] = '{1'b0, 2'd3, 1'b1, 64'h18,  64'h0,          64'h8000_0001_0000_0003, 1'b0};
        vecs[17] = '{1'b0, 2'd1, 1'b0, 64'h1E,  64'h0,          64'hFFFF_FFFF_FFFF_8000, 1'b0};
        vecs[18] = '{1'b0, 2'd1, 1'b1, 64'h1E,  64'h0,          64'h8000,               1'b0};
        vecs[19] = '{1'b0, 2'd3, 1'b0, 64'h0000_0100_0000_0008, 64'h0, 64'h0,           1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_busy",      64'(busy),      64'd1);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata,      64'd0);
        checkOutput("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        reset = 1'b0;
        waitInit(cnt);
        checkOutput("init_cycles", 64'(cnt), 64'd32);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        // Directed table
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                          vecs[i].wdata, $sformatf("vec%0d", i), r, f);
            model_access(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                         vecs[i].wdata, exp_r, exp_f);
            checkOutput($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_fault", i), 64'(f), 64'(vecs[i].exp_fault));
        end

        // Back-to-back requests: accepts LAT+1 cycles apart
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, "b2b0", r, f);
        t0 = t_accept;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h48, 64'h0, "b2b1", r, f);
        t1 = t_accept;
        checkOutput("b2b1_rdata", r, 64'd9);
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h50, 64'h0, "b2b2", r, f);
        t2 = t_accept;
        checkOutput("b2b_gap01", 64'(t1 - t0), 64'd40);
        checkOutput("b2b_gap12", 64'(t2 - t1), 64'd40);

        // Random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            logic        we, uns;
            logic [1:0]  size;
            logic [63:0] addr, wdata;
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            addr  = 64'($urandom_range(0, DEPTH*8 + 31));
            n     = 1 << size;
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(n - 1);
            if ($urandom_range(0, 15) == 0) addr[40] = 1'b1;
            wdata = {$urandom, $urandom};
            applyStimulus(we, size, uns, addr, wdata, $sformatf("rnd%0d", i), r, f);
            model_access(we, size, uns, addr, wdata, exp_r, exp_f);
            checkOutput($sformatf("rnd%0d_rdata", i), r, exp_r);
            checkOutput($sformatf("rnd%0d_fault", i), 64'(f), 64'(exp_f));
        end

        // Reset during WAIT of a store: no response, no commit, INIT reruns
        req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h10; req_wdata = 64'h55; req_valid = 1'b1;
        cnt = 0;
        while (!req_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("abort_ready_before", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("abort_in_wait_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort_no_rsp_%0d", c), 64'(rsp_valid), 64'd0);
        end
        reset = 1'b0;
        waitInit(cnt);
        checkOutput("reinit_cycles", 64'(cnt), 64'd32);
        model_init();
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, "after_abort", r, f);
        checkOutput("after_abort_rdata", r, 64'd2);
        checkOutput("after_abort_fault", 64'(f), 64'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 64'h09, 64'h0, "reinit_byte", r, f);
        model_access(1'b0, 2'd0, 1'b1, 64'h09, 64'h0, exp_r, exp_f);
        checkOutput("reinit_byte_rdata", r, exp_r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
